// File: rtl/sysarr_pkg.sv
// rtl/sysarr_pkg.sv - shared types and arithmetic helpers for the output-stationary systolic array
package sysarr_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

  // Cycles needed for the last beat to reach the far corner PE.
  function automatic int flush_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] prod,
                                                 input int width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = acc + prod;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/sysarr_mac_pe.sv
// rtl/sysarr_mac_pe.sv - one MAC PE; SYSARR_SAT_EN selects sticky saturating accumulate
module sysarr_mac_pe
  import sysarr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic                  a_vld_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  b_vld_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic                  a_vld_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  b_vld_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod_w;
  logic signed [ACC_WIDTH-1:0]    prod_ext_w;
  logic [ACC_WIDTH-1:0]           acc_q, acc_d;
  logic [DATA_WIDTH-1:0]          a_q, b_q;
  logic                           a_vld_q, b_vld_q;
  logic                           mac_en_w;

  assign prod_w     = $signed(a_i) * $signed(b_i);
  assign prod_ext_w = ACC_WIDTH'(prod_w);
  assign mac_en_w   = a_vld_i & b_vld_i;

`ifdef SYSARR_SAT_EN
  logic                sat_q, sat_d;
  logic signed [63:0]  raw_w, sum_w;

  assign raw_w = 64'($signed(acc_q)) + 64'(prod_ext_w);
  assign sum_w = sat_add(64'($signed(acc_q)), 64'(prod_ext_w), ACC_WIDTH);

  // Once clipped the accumulator parks on the rail until the next job clears it.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clear_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (mac_en_w && !sat_q) begin
      acc_d = sum_w[ACC_WIDTH-1:0];
      sat_d = (sum_w != raw_w);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end
`else
  always_comb begin
    acc_d = acc_q;
    if (clear_i)       acc_d = '0;
    else if (mac_en_w) acc_d = acc_q + prod_ext_w;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      a_q     <= a_i;
      b_q     <= b_i;
      a_vld_q <= a_vld_i;
      b_vld_q <= b_vld_i;
    end
  end

  assign a_o     = a_q;
  assign a_vld_o = a_vld_q;
  assign b_o     = b_q;
  assign b_vld_o = b_vld_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/os_systolic_array.sv
// rtl/os_systolic_array.sv - output-stationary signed matmul grid with skew, job FSM and row drain
// Optional SYSARR_SAT_EN (in sysarr_mac_pe) makes every accumulator saturate.
module os_systolic_array
  import sysarr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 4,
  parameter int MAX_K      = 1024
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic [$clog2(MAX_K+1)-1:0]                   k_len_i,
  output logic                                         busy_o,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic [NUM_ROWS*DATA_WIDTH-1:0]               a_i,
  input  logic [NUM_COLS*DATA_WIDTH-1:0]               b_i,
  output logic                                         out_valid_o,
  input  logic                                         out_ready_i,
  output logic [NUM_COLS*ACC_WIDTH-1:0]                out_data_o,
  output logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] out_row_o,
  output logic                                         out_last_o
);

  localparam int KW      = $clog2(MAX_K + 1);
  localparam int RW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int FLUSH_N = flush_cycles(NUM_ROWS, NUM_COLS);
  localparam int FW      = $clog2(FLUSH_N + 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, beat_q;
  logic [FW-1:0]   flush_q;
  logic [RW-1:0]   row_q;
  logic            accept_w, clear_w, load_done_w, flush_done_w, row_done_w;

  logic [DATA_WIDTH-1:0] a_w  [NUM_ROWS][NUM_COLS+1];
  logic                  av_w [NUM_ROWS][NUM_COLS+1];
  logic [DATA_WIDTH-1:0] b_w  [NUM_ROWS+1][NUM_COLS];
  logic                  bv_w [NUM_ROWS+1][NUM_COLS];
  logic [ACC_WIDTH-1:0]  acc_w [NUM_ROWS][NUM_COLS];

  assign accept_w     = in_valid_i & in_ready_o;
  assign clear_w      = (state_q == IDLE) & start_i;
  assign load_done_w  = accept_w & (beat_q == k_q - 1'b1);
  assign flush_done_w = (state_q == FLUSH) & (flush_q == FW'(FLUSH_N - 1));
  assign row_done_w   = out_valid_o & out_ready_i & (row_q == RW'(NUM_ROWS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (k_len_i == '0) ? DRAIN : LOAD;
      LOAD:    if (load_done_w) state_d = FLUSH;
      FLUSH:   if (flush_done_w) state_d = DRAIN;
      DRAIN:   if (row_done_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    in_ready_o  = (state_q == LOAD);
    out_valid_o = (state_q == DRAIN);
    out_last_o  = (state_q == DRAIN) & (row_q == RW'(NUM_ROWS - 1));
    out_row_o   = (state_q == DRAIN) ? row_q : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      if (clear_w) begin
        k_q    <= k_len_i;
        beat_q <= '0;
      end else if (accept_w) begin
        beat_q <= beat_q + 1'b1;
      end
      flush_q <= (state_q == FLUSH) ? flush_q + 1'b1 : '0;
      if (state_q != DRAIN || row_done_w)  row_q <= '0;
      else if (out_valid_o && out_ready_i) row_q <= row_q + 1'b1;
    end
  end

  // Skew lanes so a_k and b_k meet at PE(r,c) exactly r+c cycles after acceptance.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign a_w[0][0]  = a_i[DATA_WIDTH-1:0];
      assign av_w[0][0] = accept_w;
    end else begin : g_delay
      logic [DATA_WIDTH:0] sk_q [r];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else begin
          sk_q[0] <= {accept_w, a_i[r*DATA_WIDTH +: DATA_WIDTH]};
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign {av_w[r][0], a_w[r][0]} = sk_q[r-1];
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_direct
      assign b_w[0][0]  = b_i[DATA_WIDTH-1:0];
      assign bv_w[0][0] = accept_w;
    end else begin : g_delay
      logic [DATA_WIDTH:0] sk_q [c];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < c; i++) sk_q[i] <= '0;
        end else begin
          sk_q[0] <= {accept_w, b_i[c*DATA_WIDTH +: DATA_WIDTH]};
          for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign {bv_w[0][c], b_w[0][c]} = sk_q[c-1];
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      sysarr_mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_w),
        .a_i     (a_w[r][c]),
        .a_vld_i (av_w[r][c]),
        .b_i     (b_w[r][c]),
        .b_vld_i (bv_w[r][c]),
        .a_o     (a_w[r][c+1]),
        .a_vld_o (av_w[r][c+1]),
        .b_o     (b_w[r+1][c]),
        .b_vld_o (bv_w[r+1][c]),
        .acc_o   (acc_w[r][c])
      );
    end
  end

  always_comb begin
    out_data_o = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < NUM_COLS; c++) out_data_o[c*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_q][c];
    end
  end

endmodule

// File: tb/tb_os_systolic_array.sv
// tb/tb_os_systolic_array.sv - scoreboard bench for os_systolic_array (32-bit and 16-bit acc instances)
module tb_os_systolic_array;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KW = $clog2(1024 + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic [R*DW-1:0] a;
  logic [C*DW-1:0] b;
  logic            out_ready;

  logic            busy, in_ready, out_valid, out_last;
  logic [C*32-1:0] out_data;
  logic [1:0]      out_row;
  logic            busy16, in_ready16, out_valid16, out_last16;
  logic [C*16-1:0] out_data16;
  logic [1:0]      out_row16;

  int     errors = 0;
  int     checks = 0;
  longint exp_q[$];
  int     av[64][4];
  int     bv[64][4];

  always #5 clk = ~clk;

  os_systolic_array dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len), .busy_o(busy),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_row_o(out_row), .out_last_o(out_last)
  );

  os_systolic_array #(.ACC_WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len), .busy_o(busy16),
    .in_valid_i(in_valid), .in_ready_o(in_ready16), .a_i(a), .b_i(b),
    .out_valid_o(out_valid16), .out_ready_i(out_ready), .out_data_o(out_data16),
    .out_row_o(out_row16), .out_last_o(out_last16)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fit16(input longint v);
`ifdef SYSARR_SAT_EN
    if (v > 64'sd32767) return 64'sd32767;
    if (v < -64'sd32768) return -64'sd32768;
    return v;
`else
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
`endif
  endfunction

  task automatic drain(input int stall, input bit poke);
    longint e [C];
    int     n;
    for (int r = 0; r < R; r++) begin
      n = 0;
      while (!out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("out_valid", longint'(out_valid), 1);
      for (int c = 0; c < C; c++) e[c] = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd0;
      for (int s = 0; s <= stall; s++) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("out_row", longint'(out_row), longint'(r));
        chk("out_last", longint'(out_last), longint'(r == R - 1));
        for (int c = 0; c < C; c++) begin
          chk("data32", longint'($signed(out_data[c*32 +: 32])), e[c]);
          chk("data16", longint'($signed(out_data16[c*16 +: 16])), fit16(e[c]));
        end
        if (s < stall) @(negedge clk);
      end
      out_ready = 1'b1;
      if (poke && (r == 1 || r == R - 1)) start = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
    end
    chk("busy_after_drain", longint'(busy), 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk("no_extra_rows", longint'(out_valid), 0);
      chk("no_restart", longint'(busy), 0);
    end
  endtask

  task automatic run_job(input int k, input bit tog, input int stall, input bit poke);
    longint m [R][C];
    int     i;
    int     cyc;
    bit     ph;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m[r][c] = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    if (k == 0) chk("k0_in_ready", longint'(in_ready), 0);
    i   = 0;
    cyc = 0;
    ph  = 1'b1;
    while (i < k && cyc < 500) begin
      in_valid = tog ? ph : 1'b1;
      ph = !ph;
      for (int l = 0; l < 4; l++) begin
        a[l*DW +: DW] = DW'(av[i][l]);
        b[l*DW +: DW] = DW'(bv[i][l]);
      end
      if (in_valid && in_ready) begin
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++) m[r][c] += longint'(av[i][r] * bv[i][c]);
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("beats_accepted", longint'(i), longint'(k));
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) exp_q.push_back(m[r][c]);
    drain(stall, poke);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    rst = 1'b0;

    // k=1 outer product
    for (int l = 0; l < 4; l++) begin av[0][l] = l + 1; bv[0][l] = l + 5; end
    run_job(1, 1'b0, 0, 1'b0);

    // identity-selected rows with bubbles, then with back-pressure
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++) begin av[k][l] = (l == k) ? 1 : 0; bv[k][l] = k + 1 + l; end
    run_job(4, 1'b1, 0, 1'b0);
    run_job(4, 1'b1, 3, 1'b0);

    run_job(0, 1'b0, 0, 1'b0);

    // large products exercise 16-bit wrap / saturation
    for (int k = 0; k < 5; k++)
      for (int l = 0; l < 4; l++) begin av[k][l] = 127; bv[k][l] = 127; end
    run_job(5, 1'b0, 0, 1'b0);

    // reset in the middle of a load
    for (int l = 0; l < 4; l++) begin av[0][l] = 9; bv[0][l] = 9; end
    @(negedge clk);
    start = 1'b1; k_len = KW'(4);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a = {4{8'd9}}; b = {4{8'd9}};
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_out_last", longint'(out_last), 0);
    chk("mid_rst_out_row", longint'(out_row), 0);
    chk("mid_rst_out_data", longint'(out_data), 0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++)
      for (int l = 0; l < 4; l++) begin
        av[k][l] = int'($urandom_range(40, 0)) - 20;
        bv[k][l] = int'($urandom_range(40, 0)) - 20;
      end
    run_job(8, 1'b1, 1, 1'b1);

    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
